// File: rtl/id_stage_pipe_pkg.sv
// Shared RV32I encodings and decoded-operation enums for the ID stage.
package id_stage_pipe_pkg;

    localparam int ALU_Len    = 5;
    localparam int Jump_Len   = 2;
    localparam int Branch_Len = 3;

    // Major opcodes
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // funct3: arithmetic
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    // funct3: branches
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    // funct3: memory access size
    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic ImmUsed    = 1'b1;
    localparam logic ImmNotUsed = 1'b0;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [ALU_Len-1:0] {
        NoAlu, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        LUI, AUIPC, LB, LH, LW, LBU, LHU, SB, SH, SW
    } alu_op_e;

    typedef enum logic [Jump_Len-1:0] { NoJump, JAL, JALR } jump_op_e;

    typedef enum logic [Branch_Len-1:0] {
        NoBranch, BEQ, BNE, BLT, BGE, BLTU, BGEU
    } branch_op_e;

    typedef struct packed {
        alu_op_e    alu_op;
        jump_op_e   jump_op;
        branch_op_e branch_op;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rd_en;
        logic        rs1_used;
        logic        rs2_used;
        logic        use_imm;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/id_stage_pipe_if.sv
// IF->ID request side and ID->EX pipeline-register side of the decode stage.
interface id_stage_pipe_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    import id_stage_pipe_pkg::*;

    logic                  if_valid;
    logic                  if_ready;
    logic [XLEN-1:0]       if_pc;
    logic [31:0]           if_inst;

    logic                  ex_valid;
    logic                  ex_ready;
    logic [XLEN-1:0]       ex_pc;
    logic [XLEN-1:0]       ex_reg1;
    logic [XLEN-1:0]       ex_reg2;
    logic [XLEN-1:0]       ex_imm;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_rd_en;
    alu_op_e               ex_alu_op;
    jump_op_e              ex_jump_op;
    branch_op_e            ex_branch_op;
    logic                  ex_illegal;

    // Environment side: fetch stage upstream, execute stage downstream.
    modport master (
        output if_valid, if_pc, if_inst, ex_ready,
        input  if_ready, ex_valid, ex_pc, ex_reg1, ex_reg2, ex_imm, ex_rd,
               ex_rd_en, ex_alu_op, ex_jump_op, ex_branch_op, ex_illegal
    );

    // Decode stage side.
    modport slave (
        input  if_valid, if_pc, if_inst, ex_ready,
        output if_ready, ex_valid, ex_pc, ex_reg1, ex_reg2, ex_imm, ex_rd,
               ex_rd_en, ex_alu_op, ex_jump_op, ex_branch_op, ex_illegal
    );
endinterface

// File: rtl/id_stage_pipe_rv32i_decode.sv
// Purely combinational RV32I instruction decoder.
module rv32i_decode
    import id_stage_pipe_pkg::*;
(
    input  logic [31:0] i_inst,
    output dec_t        o_dec
);
    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_opc   = i_inst[6:0];
    assign w_f3    = i_inst[14:12];
    assign w_f7    = i_inst[31:25];
    assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u = {i_inst[31:12], 12'h000};
    assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    // Format/operation decode; an unrecognised encoding collapses to an inert illegal op.
    always_comb begin
        logic w_bad;
        // NOTE: every field gets a default before the case so no path can infer a latch.
        w_bad           = 1'b0;
        o_dec           = '0;
        o_dec.alu_op    = NoAlu;
        o_dec.jump_op   = NoJump;
        o_dec.branch_op = NoBranch;
        o_dec.imm       = ZERO_WORD;
        o_dec.use_imm   = ImmNotUsed;

        case (w_opc)
            OPC_OP_IMM: begin
                o_dec.rs1_used = 1'b1;
                o_dec.rd_en    = 1'b1;
                o_dec.use_imm  = ImmUsed;
                o_dec.imm      = w_imm_i;
                case (w_f3)
                    F3_ADD:  o_dec.alu_op = ADDI;
                    F3_SLT:  o_dec.alu_op = SLTI;
                    F3_SLTU: o_dec.alu_op = SLTIU;
                    F3_XOR:  o_dec.alu_op = XORI;
                    F3_OR:   o_dec.alu_op = ORI;
                    F3_AND:  o_dec.alu_op = ANDI;
                    F3_SLL:  if (w_f7 == F7_BASE) o_dec.alu_op = SLLI; else w_bad = 1'b1;
                    default: begin
                        if (w_f7 == F7_BASE)     o_dec.alu_op = SRLI;
                        else if (w_f7 == F7_ALT) o_dec.alu_op = SRAI;
                        else                     w_bad = 1'b1;
                    end
                endcase
            end
            OPC_LOAD: begin
                o_dec.rs1_used = 1'b1;
                o_dec.rd_en    = 1'b1;
                o_dec.use_imm  = ImmUsed;
                o_dec.imm      = w_imm_i;
                case (w_f3)
                    F3_B:    o_dec.alu_op = LB;
                    F3_H:    o_dec.alu_op = LH;
                    F3_W:    o_dec.alu_op = LW;
                    F3_BU:   o_dec.alu_op = LBU;
                    F3_HU:   o_dec.alu_op = LHU;
                    default: w_bad = 1'b1;
                endcase
            end
            OPC_JALR: begin
                o_dec.rs1_used = 1'b1;
                o_dec.rd_en    = 1'b1;
                o_dec.use_imm  = ImmUsed;
                o_dec.imm      = w_imm_i;
                o_dec.jump_op  = JALR;
                if (w_f3 != 3'b000) w_bad = 1'b1;
            end
            OPC_OP: begin
                o_dec.rs1_used = 1'b1;
                o_dec.rs2_used = 1'b1;
                o_dec.rd_en    = 1'b1;
                if (w_f7 == F7_BASE) begin
                    case (w_f3)
                        F3_ADD:  o_dec.alu_op = ADD;
                        F3_SLL:  o_dec.alu_op = SLL;
                        F3_SLT:  o_dec.alu_op = SLT;
                        F3_SLTU: o_dec.alu_op = SLTU;
                        F3_XOR:  o_dec.alu_op = XOR;
                        F3_SR:   o_dec.alu_op = SRL;
                        F3_OR:   o_dec.alu_op = OR;
                        default: o_dec.alu_op = AND;
                    endcase
                end else if (w_f7 == F7_ALT && w_f3 == F3_ADD) begin
                    o_dec.alu_op = SUB;
                end else if (w_f7 == F7_ALT && w_f3 == F3_SR) begin
                    o_dec.alu_op = SRA;
                end else begin
                    w_bad = 1'b1;
                end
            end
            OPC_BRANCH: begin
                o_dec.rs1_used = 1'b1;
                o_dec.rs2_used = 1'b1;
                o_dec.imm      = w_imm_b;
                case (w_f3)
                    F3_BEQ:  o_dec.branch_op = BEQ;
                    F3_BNE:  o_dec.branch_op = BNE;
                    F3_BLT:  o_dec.branch_op = BLT;
                    F3_BGE:  o_dec.branch_op = BGE;
                    F3_BLTU: o_dec.branch_op = BLTU;
                    F3_BGEU: o_dec.branch_op = BGEU;
                    default: w_bad = 1'b1;
                endcase
            end
            OPC_STORE: begin
                o_dec.rs1_used = 1'b1;
                o_dec.rs2_used = 1'b1;
                o_dec.imm      = w_imm_s;
                case (w_f3)
                    F3_B:    o_dec.alu_op = SB;
                    F3_H:    o_dec.alu_op = SH;
                    F3_W:    o_dec.alu_op = SW;
                    default: w_bad = 1'b1;
                endcase
            end
            OPC_LUI: begin
                o_dec.rd_en   = 1'b1;
                o_dec.use_imm = ImmUsed;
                o_dec.imm     = w_imm_u;
                o_dec.alu_op  = LUI;
            end
            OPC_AUIPC: begin
                o_dec.rd_en   = 1'b1;
                o_dec.use_imm = ImmUsed;
                o_dec.imm     = w_imm_u;
                o_dec.alu_op  = AUIPC;
            end
            OPC_JAL: begin
                o_dec.rd_en   = 1'b1;
                o_dec.use_imm = ImmUsed;
                o_dec.imm     = w_imm_j;
                o_dec.jump_op = JAL;
            end
            default: w_bad = 1'b1;
        endcase

        // Illegal ops read nothing and write nothing so they can never stall or corrupt state.
        if (w_bad) begin
            o_dec           = '0;
            o_dec.alu_op    = NoAlu;
            o_dec.jump_op   = NoJump;
            o_dec.branch_op = NoBranch;
            o_dec.illegal   = 1'b1;
        end
        o_dec.rd = o_dec.rd_en ? i_inst[11:7] : 5'd0;
    end
endmodule

// File: rtl/id_stage_pipe.sv
// Registered RV32I decode stage: decode, operand forwarding, hazard stall, ID/EX register.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit ENABLE_FWD = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    id_stage_pipe_if.slave        bus,
    output logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic                  ex_wr_en,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_wr_addr,
    input  logic [XLEN-1:0]       ex_wr_data,
    input  logic                  mem_wr_en,
    input  logic [REG_ADDR_W-1:0] mem_wr_addr,
    input  logic [XLEN-1:0]       mem_wr_data,
    input  logic                  flush
);
    dec_t                  w_dec;
    logic [REG_ADDR_W-1:0] w_rs1, w_rs2;
    logic [XLEN-1:0]       w_imm, w_op1, w_op2;
    logic                  w_rs1_live, w_rs2_live;
    logic                  w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2;
    logic                  w_hz, w_adv, w_accept;

    logic                  r_valid;
    logic [XLEN-1:0]       r_pc, r_reg1, r_reg2, r_imm;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_rd_en;
    alu_op_e               r_alu_op;
    jump_op_e              r_jump_op;
    branch_op_e            r_branch_op;
    logic                  r_illegal;

    rv32i_decode u_decode (
        .i_inst (bus.if_inst),
        .o_dec  (w_dec)
    );

    assign w_rs1    = REG_ADDR_W'(bus.if_inst[19:15]);
    assign w_rs2    = REG_ADDR_W'(bus.if_inst[24:20]);
    assign rs1_addr = w_rs1;
    assign rs2_addr = w_rs2;
    assign w_imm    = XLEN'($signed(w_dec.imm));

    // x0 is hard-wired zero, so it is never a real dependency.
    assign w_rs1_live = w_dec.rs1_used && (w_rs1 != '0);
    assign w_rs2_live = w_dec.rs2_used && (w_rs2 != '0);
    assign w_ex_m1    = w_rs1_live && ex_wr_en && (ex_wr_addr == w_rs1);
    assign w_ex_m2    = w_rs2_live && ex_wr_en && (ex_wr_addr == w_rs2);
    assign w_mem_m1   = w_rs1_live && mem_wr_en && (mem_wr_addr == w_rs1);
    assign w_mem_m2   = w_rs2_live && mem_wr_en && (mem_wr_addr == w_rs2);

    // With forwarding only a load result in EX is unavailable; without it any pending write stalls.
    assign w_hz = ENABLE_FWD ? (ex_is_load && (w_ex_m1 || w_ex_m2))
                             : (w_ex_m1 || w_ex_m2 || w_mem_m1 || w_mem_m2);

    assign w_adv        = !r_valid || bus.ex_ready;
    assign bus.if_ready = w_adv && !w_hz && !flush && !rst;
    assign w_accept     = bus.if_valid && bus.if_ready;

    // Operand 1: EX result beats MEM result beats regfile; unread or x0 gives zero.
    always_comb begin
        w_op1 = '0;
        if (w_rs1_live) begin
            if (ENABLE_FWD && w_ex_m1 && !ex_is_load) w_op1 = ex_wr_data;
            else if (ENABLE_FWD && w_mem_m1)          w_op1 = mem_wr_data;
            else                                      w_op1 = rs1_data;
        end
    end

    // Operand 2: same priority as operand 1, immediate substituted when rs2 is not read.
    always_comb begin
        w_op2 = '0;
        if (w_rs2_live) begin
            if (ENABLE_FWD && w_ex_m2 && !ex_is_load) w_op2 = ex_wr_data;
            else if (ENABLE_FWD && w_mem_m2)          w_op2 = mem_wr_data;
            else                                      w_op2 = rs2_data;
        end else if (!w_dec.rs2_used && w_dec.use_imm) begin
            w_op2 = w_imm;
        end
    end

    // ID/EX register: reset > flush > accept > bubble > hold under back-pressure.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_reg1      <= '0;
            r_reg2      <= '0;
            r_imm       <= '0;
            r_rd        <= '0;
            r_rd_en     <= 1'b0;
            r_alu_op    <= NoAlu;
            r_jump_op   <= NoJump;
            r_branch_op <= NoBranch;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_rd_en <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_pc        <= bus.if_pc;
            r_reg1      <= w_op1;
            r_reg2      <= w_op2;
            r_imm       <= w_imm;
            r_rd        <= REG_ADDR_W'(w_dec.rd);
            r_rd_en     <= w_dec.rd_en;
            r_alu_op    <= w_dec.alu_op;
            r_jump_op   <= w_dec.jump_op;
            r_branch_op <= w_dec.branch_op;
            r_illegal   <= w_dec.illegal;
        end else if (w_adv) begin
            r_valid <= 1'b0;
            r_rd_en <= 1'b0;
        end
    end

    assign bus.ex_valid     = r_valid;
    assign bus.ex_pc        = r_pc;
    assign bus.ex_reg1      = r_reg1;
    assign bus.ex_reg2      = r_reg2;
    assign bus.ex_imm       = r_imm;
    assign bus.ex_rd        = r_rd;
    assign bus.ex_rd_en     = r_rd_en;
    assign bus.ex_alu_op    = r_alu_op;
    assign bus.ex_jump_op   = r_jump_op;
    assign bus.ex_branch_op = r_branch_op;
    assign bus.ex_illegal   = r_illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench: forwarding DUT plus a no-forwarding DUT driven with the same stimulus.
module tb_id_stage_pipe;
    import id_stage_pipe_pkg::*;

    localparam logic [31:0] I_ADDI_X1_5   = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_ADD_X3_X1X2 = 32'h0020_81B3; // add  x3,x1,x2
    localparam logic [31:0] I_ADD_X6_X5X0 = 32'h0002_8333; // add  x6,x5,x0
    localparam logic [31:0] I_ADDI_X7_3   = 32'h0030_0393; // addi x7,x0,3
    localparam logic [31:0] I_BEQ_M8      = 32'hFE20_8CE3; // beq  x1,x2,-8
    localparam logic [31:0] I_BAD_OPC     = 32'h0000_007F;
    localparam logic [31:0] I_MUL         = 32'h0220_81B3; // funct7=1: not RV32I
    localparam logic [31:0] I_LUI_X8      = 32'h1234_5437; // lui  x8,0x12345
    localparam logic [31:0] I_JAL_X1_8    = 32'h0080_00EF; // jal  x1,+8

    logic        clk, rst, flush;
    logic        if_valid, ex_ready;
    logic [31:0] if_pc, if_inst, rs1_data, rs2_data;
    logic        ex_wr_en, ex_is_load, mem_wr_en;
    logic [4:0]  ex_wr_addr, mem_wr_addr;
    logic [31:0] ex_wr_data, mem_wr_data;
    logic [4:0]  f_rs1_addr, f_rs2_addr, n_rs1_addr, n_rs2_addr;

    int n_checks = 0;
    int n_errors = 0;

    id_stage_pipe_if #(.XLEN(32), .REG_ADDR_W(5)) bus_f ();
    id_stage_pipe_if #(.XLEN(32), .REG_ADDR_W(5)) bus_n ();

    assign bus_f.if_valid = if_valid;
    assign bus_f.if_pc    = if_pc;
    assign bus_f.if_inst  = if_inst;
    assign bus_f.ex_ready = ex_ready;
    assign bus_n.if_valid = if_valid;
    assign bus_n.if_pc    = if_pc;
    assign bus_n.if_inst  = if_inst;
    assign bus_n.ex_ready = ex_ready;

    id_stage_pipe #(.XLEN(32), .REG_ADDR_W(5), .ENABLE_FWD(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus_f),
        .rs1_addr(f_rs1_addr), .rs2_addr(f_rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
        .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .flush(flush)
    );

    id_stage_pipe #(.XLEN(32), .REG_ADDR_W(5), .ENABLE_FWD(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .bus(bus_n),
        .rs1_addr(n_rs1_addr), .rs2_addr(n_rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
        .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and land 1 ns after it, away from the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bypass();
        ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_wr_addr = '0; ex_wr_data = '0;
        mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        if_pc = '0; if_inst = I_ADDI_X1_5; rs1_data = '0; rs2_data = '0;
        clear_bypass();
        step();
        step();

        // Reset state
        check("rst_if_ready", 32'(bus_f.if_ready), 32'd0);
        check("rst_ex_valid", 32'(bus_f.ex_valid), 32'd0);
        check("rst_rd_en",    32'(bus_f.ex_rd_en), 32'd0);
        check("rst_alu_op",   32'(bus_f.ex_alu_op), 32'(NoAlu));
        check("rst_reg2",     bus_f.ex_reg2, 32'd0);

        // addi x1,x0,5: x0 reads zero even with junk on the regfile port
        rst = 1'b0; if_valid = 1'b1; if_pc = 32'h100; if_inst = I_ADDI_X1_5;
        rs1_data = 32'hDEAD_BEEF;
        #1;
        check("addi_if_ready", 32'(bus_f.if_ready), 32'd1);
        step();
        check("addi_valid", 32'(bus_f.ex_valid), 32'd1);
        check("addi_pc",    bus_f.ex_pc, 32'h100);
        check("addi_reg1",  bus_f.ex_reg1, 32'd0);
        check("addi_reg2",  bus_f.ex_reg2, 32'd5);
        check("addi_imm",   bus_f.ex_imm, 32'd5);
        check("addi_rd",    32'(bus_f.ex_rd), 32'd1);
        check("addi_rd_en", 32'(bus_f.ex_rd_en), 32'd1);
        check("addi_alu",   32'(bus_f.ex_alu_op), 32'(ADDI));

        // add x3,x1,x2 with both EX and MEM writing x1: EX wins
        if_pc = 32'h104; if_inst = I_ADD_X3_X1X2; rs1_data = 32'h11; rs2_data = 32'h4;
        ex_wr_en = 1'b1; ex_wr_addr = 5'd1; ex_wr_data = 32'd7;
        mem_wr_en = 1'b1; mem_wr_addr = 5'd1; mem_wr_data = 32'd9;
        #1;
        check("add_rs1_addr",    32'(f_rs1_addr), 32'd1);
        check("add_rs2_addr",    32'(f_rs2_addr), 32'd2);
        check("fwd_if_ready",    32'(bus_f.if_ready), 32'd1);
        check("nofwd_if_ready",  32'(bus_n.if_ready), 32'd0);
        step();
        check("fwd_ex_reg1",     bus_f.ex_reg1, 32'd7);
        check("fwd_ex_reg2",     bus_f.ex_reg2, 32'd4);
        check("fwd_ex_rd",       32'(bus_f.ex_rd), 32'd3);
        check("fwd_alu",         32'(bus_f.ex_alu_op), 32'(ADD));
        check("nofwd_bubble",    32'(bus_n.ex_valid), 32'd0);
        check("nofwd_bub_rd_en", 32'(bus_n.ex_rd_en), 32'd0);

        // Only MEM writes x1: MEM value forwarded; no-forward DUT still stalls
        if_pc = 32'h108; ex_wr_en = 1'b0;
        #1;
        check("nofwd_mem_stall", 32'(bus_n.if_ready), 32'd0);
        step();
        check("fwd_mem_reg1",    bus_f.ex_reg1, 32'd9);
        check("fwd_mem_pc",      bus_f.ex_pc, 32'h108);

        // Hazard gone: both DUTs accept with regfile operands
        if_pc = 32'h10C; mem_wr_en = 1'b0;
        #1;
        check("nofwd_clear_rdy", 32'(bus_n.if_ready), 32'd1);
        step();
        check("fwd_rf_reg1",     bus_f.ex_reg1, 32'h11);
        check("nofwd_rf_valid",  32'(bus_n.ex_valid), 32'd1);
        check("nofwd_rf_reg1",   bus_n.ex_reg1, 32'h11);

        // Load-use: lw x5 in EX, IF presents add x6,x5,x0
        if_pc = 32'h110; if_inst = I_ADD_X6_X5X0;
        ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 5'd5; ex_wr_data = 32'hBAD;
        #1;
        check("lu_if_ready", 32'(bus_f.if_ready), 32'd0);
        step();
        check("lu_bubble",   32'(bus_f.ex_valid), 32'd0);
        check("lu_rd_en",    32'(bus_f.ex_rd_en), 32'd0);
        // Load has moved to MEM
        clear_bypass();
        mem_wr_en = 1'b1; mem_wr_addr = 5'd5; mem_wr_data = 32'h55;
        #1;
        check("lu_release_rdy", 32'(bus_f.if_ready), 32'd1);
        step();
        check("lu_valid", 32'(bus_f.ex_valid), 32'd1);
        check("lu_reg1",  bus_f.ex_reg1, 32'h55);
        check("lu_reg2",  bus_f.ex_reg2, 32'd0);
        check("lu_rd",    32'(bus_f.ex_rd), 32'd6);

        // Back-pressure for 3 cycles: outputs frozen, IF not accepted
        clear_bypass();
        ex_ready = 1'b0; if_pc = 32'h114; if_inst = I_ADDI_X7_3;
        for (int i = 0; i < 3; i++) begin
            rs1_data = 32'h1000 + 32'(i);
            #1;
            check("bp_if_ready", 32'(bus_f.if_ready), 32'd0);
            step();
            check("bp_valid", 32'(bus_f.ex_valid), 32'd1);
            check("bp_pc",    bus_f.ex_pc, 32'h110);
            check("bp_reg1",  bus_f.ex_reg1, 32'h55);
            check("bp_rd",    32'(bus_f.ex_rd), 32'd6);
            check("bp_rd_en", 32'(bus_f.ex_rd_en), 32'd1);
        end
        ex_ready = 1'b1;
        #1;
        check("bp_release_rdy", 32'(bus_f.if_ready), 32'd1);
        step();
        check("bp_next_pc",   bus_f.ex_pc, 32'h114);
        check("bp_next_reg2", bus_f.ex_reg2, 32'd3);
        check("bp_next_rd",   32'(bus_f.ex_rd), 32'd7);

        // Flush while stalled by back-pressure
        ex_ready = 1'b0; flush = 1'b1; if_pc = 32'h118;
        #1;
        check("fl_stall_rdy", 32'(bus_f.if_ready), 32'd0);
        step();
        check("fl_stall_valid", 32'(bus_f.ex_valid), 32'd0);
        check("fl_stall_rd_en", 32'(bus_f.ex_rd_en), 32'd0);
        // Flush beats an otherwise acceptable instruction
        ex_ready = 1'b1;
        #1;
        check("fl_acc_rdy", 32'(bus_f.if_ready), 32'd0);
        step();
        check("fl_acc_valid", 32'(bus_f.ex_valid), 32'd0);
        flush = 1'b0;

        // beq x1,x2,-8
        if_pc = 32'h200; if_inst = I_BEQ_M8; rs1_data = 32'h1; rs2_data = 32'h2;
        step();
        check("beq_valid",  32'(bus_f.ex_valid), 32'd1);
        check("beq_imm",    bus_f.ex_imm, 32'hFFFF_FFF8);
        check("beq_branch", 32'(bus_f.ex_branch_op), 32'(BEQ));
        check("beq_rd_en",  32'(bus_f.ex_rd_en), 32'd0);
        check("beq_reg1",   bus_f.ex_reg1, 32'h1);
        check("beq_reg2",   bus_f.ex_reg2, 32'h2);
        check("beq_alu",    32'(bus_f.ex_alu_op), 32'(NoAlu));

        // Unknown opcode still flows down the pipe
        if_pc = 32'h204; if_inst = I_BAD_OPC;
        step();
        check("ill_valid", 32'(bus_f.ex_valid), 32'd1);
        check("ill_flag",  32'(bus_f.ex_illegal), 32'd1);
        check("ill_alu",   32'(bus_f.ex_alu_op), 32'(NoAlu));
        check("ill_rd_en", 32'(bus_f.ex_rd_en), 32'd0);

        // OP opcode with unknown funct7
        if_pc = 32'h208; if_inst = I_MUL;
        step();
        check("f7_ill_flag",  32'(bus_f.ex_illegal), 32'd1);
        check("f7_ill_rd_en", 32'(bus_f.ex_rd_en), 32'd0);

        // lui x8,0x12345
        if_pc = 32'h20C; if_inst = I_LUI_X8;
        step();
        check("lui_illegal", 32'(bus_f.ex_illegal), 32'd0);
        check("lui_imm",     bus_f.ex_imm, 32'h1234_5000);
        check("lui_reg1",    bus_f.ex_reg1, 32'd0);
        check("lui_reg2",    bus_f.ex_reg2, 32'h1234_5000);
        check("lui_alu",     32'(bus_f.ex_alu_op), 32'(LUI));
        check("lui_rd",      32'(bus_f.ex_rd), 32'd8);

        // jal x1,+8
        if_pc = 32'h210; if_inst = I_JAL_X1_8;
        step();
        check("jal_imm",  bus_f.ex_imm, 32'd8);
        check("jal_jump", 32'(bus_f.ex_jump_op), 32'(JAL));
        check("jal_rd",   32'(bus_f.ex_rd), 32'd1);
        check("jal_pc",   bus_f.ex_pc, 32'h210);

        // Reset together with flush and a valid instruction: reset values win
        rst = 1'b1; flush = 1'b1; if_pc = 32'h300; if_inst = I_ADDI_X1_5;
        step();
        check("rstfl_valid", 32'(bus_f.ex_valid), 32'd0);
        check("rstfl_pc",    bus_f.ex_pc, 32'd0);
        check("rstfl_imm",   bus_f.ex_imm, 32'd0);
        check("rstfl_jump",  32'(bus_f.ex_jump_op), 32'(NoJump));
        check("rstfl_rd",    32'(bus_f.ex_rd), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
